// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory request front end.
package mem_access_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 16;
    localparam int WORD_ADDR_BITS = 10;

    localparam int MEM_WORDS = 1024;
    localparam logic [ADDR_WIDTH-1:0] MEM_MAX_BYTE_ADDR = 16'h07FE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational byte-address check: flags unaligned or out-of-range accesses.
// Only instantiated by mem_access_unit when MEM_FAULT_CHECK_EN is defined.
module mem_addr_check
    import mem_access_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  fault_o
);

    // Any bit above the word index means the address is past the last word.
    assign fault_o = addr_i[0] | (|addr_i[ADDR_WIDTH-1:WORD_ADDR_BITS+1]);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the 16-bit synchronous data memory.
// Define MEM_FAULT_CHECK_EN to reject unaligned/out-of-range requests.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [DATA_WIDTH-1:0] ReqData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] RespData,
    output logic                  Fault,
    output logic [DATA_WIDTH-1:0] MemData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemoryWrite,
    output logic                  MemoryRead,
    input  logic [DATA_WIDTH-1:0] MemOutput
);

    state_e                state_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic                  fault_q;
    logic                  mem_write_q;
    logic                  mem_read_q;
    logic                  is_store_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic req_fault;
    logic accept;

`ifdef MEM_FAULT_CHECK_EN
    mem_addr_check u_addr_check (
        .addr_i  (ReqAddress),
        .fault_o (req_fault)
    );
`else
    assign req_fault = 1'b0;
`endif

    assign accept = ReqValid && ready_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            is_store_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        mem_addr_q <= ReqAddress;
                        mem_data_q <= ReqData;
                        is_store_q <= ReqWrite;
                        fault_q    <= req_fault;
                        if (req_fault) begin
                            // Rejected requests answer next cycle without touching memory.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            ready_q      <= 1'b1;
                        end else begin
                            state_q      <= ACCESS;
                            resp_valid_q <= 1'b0;
                            ready_q      <= 1'b0;
                            mem_write_q  <= ReqWrite;
                            mem_read_q   <= !ReqWrite;
                        end
                    end else begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    if (is_store_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        ready_q      <= 1'b1;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Memory output is registered, so it is valid one cycle after ACCESS.
                    resp_data_q  <= MemOutput;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    mem_write_q  <= 1'b0;
                    mem_read_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ReqReady    = ready_q;
    assign RespValid   = resp_valid_q;
    assign RespData    = resp_data_q;
    assign Fault       = fault_q;
    assign MemData     = mem_data_q;
    assign MemAddress  = mem_addr_q;
    assign MemoryWrite = mem_write_q;
    assign MemoryRead  = mem_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: stand-in synchronous memory, cycle-indexed
// expectation model, per-cycle compare plus directed literal checks.
module tb_mem_access_unit;

    localparam int N = 1024;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [15:0] ReqAddress = 16'h0000;
    logic [15:0] ReqData = 16'h0000;
    logic        ReqReady;
    logic        RespValid;
    logic [15:0] RespData;
    logic        Fault;
    logic [15:0] MemData;
    logic [15:0] MemAddress;
    logic        MemoryWrite;
    logic        MemoryRead;
    logic [15:0] MemOutput;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqWrite    (ReqWrite),
        .ReqAddress  (ReqAddress),
        .ReqData     (ReqData),
        .RespValid   (RespValid),
        .RespData    (RespData),
        .Fault       (Fault),
        .MemData     (MemData),
        .MemAddress  (MemAddress),
        .MemoryWrite (MemoryWrite),
        .MemoryRead  (MemoryRead),
        .MemOutput   (MemOutput)
    );

    // Stand-in for the memory wrapper: always-on registered read, ignores Reset.
    logic [15:0] mem_arr [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 16'h0000;
        MemOutput = 16'h0000;
    end
    always @(posedge CLK) begin
        if (MemoryWrite) mem_arr[MemAddress[10:1]] <= MemData;
        MemOutput <= mem_arr[MemAddress[10:1]];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Expectation model, indexed by clock period (period c follows rising edge c).
    bit          exp_rv   [N];
    bit          exp_fl   [N];
    bit          exp_mw   [N];
    bit          exp_mr   [N];
    bit          exp_busy [N];
    bit          exp_mdv  [N];
    bit          rd_set   [N];
    bit          rd_zero  [N];
    logic [15:0] exp_ma   [N];
    logic [15:0] exp_md   [N];
    logic [15:0] rd_val   [N];
    logic [15:0] ref_mem  [1024];
    logic [15:0] rd_m = 16'h0000;
    int          next_edge = 0;
    bit          chk_en = 1'b0;

    initial for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;

    function automatic bit model_fault(input logic [15:0] a);
`ifdef MEM_FAULT_CHECK_EN
        return (a % 2 != 0) || (a > 16'h07FE);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / 2) % 1024;
    endfunction

    always @(negedge CLK) begin
        if (chk_en && cyc < N) begin
            if (rd_zero[cyc]) rd_m = 16'h0000;
            if (rd_set[cyc])  rd_m = rd_val[cyc];
            chk1("ReqReady", ReqReady, !exp_busy[cyc]);
            chk1("RespValid", RespValid, exp_rv[cyc]);
            if (exp_rv[cyc]) chk1("Fault", Fault, exp_fl[cyc]);
`ifndef MEM_FAULT_CHECK_EN
            chk1("Fault_tied", Fault, 1'b0);
`endif
            chk16("RespData", RespData, rd_m);
            chk1("MemoryWrite", MemoryWrite, exp_mw[cyc]);
            chk1("MemoryRead", MemoryRead, exp_mr[cyc]);
            if (exp_mw[cyc] || exp_mr[cyc]) chk16("MemAddress", MemAddress, exp_ma[cyc]);
            if (exp_mdv[cyc]) chk16("MemData", MemData, exp_md[cyc]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        ReqValid = 1'b0;
        step(n);
    endtask

    // Present a request and return in the first period after it is accepted.
    task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d);
        int  e;
        int  k;
        bit  f;
        ReqValid   = 1'b1;
        ReqWrite   = w;
        ReqAddress = a;
        ReqData    = d;
        e = (cyc + 1 > next_edge) ? cyc + 1 : next_edge;
        k = e;
        f = model_fault(a);
        if (k + 3 < N) begin
            if (f) begin
                exp_rv[k] = 1'b1;
                exp_fl[k] = 1'b1;
                next_edge = e + 1;
            end else if (w) begin
                exp_mw[k] = 1'b1; exp_ma[k] = a; exp_mdv[k] = 1'b1; exp_md[k] = d;
                exp_busy[k] = 1'b1;
                exp_rv[k+1] = 1'b1; exp_fl[k+1] = 1'b0;
                ref_mem[word_of(a)] = d;
                next_edge = e + 2;
            end else begin
                exp_mr[k] = 1'b1; exp_ma[k] = a;
                exp_busy[k] = 1'b1; exp_busy[k+1] = 1'b1;
                exp_rv[k+2] = 1'b1; exp_fl[k+2] = 1'b0;
                rd_set[k+2] = 1'b1; rd_val[k+2] = ref_mem[word_of(a)];
                next_edge = e + 3;
            end
        end
        while (cyc < e) @(negedge CLK);
        #1;
    endtask

    // Reset over one rising edge; hold_req keeps ReqValid high across that edge.
    task automatic do_reset(input bit hold_req);
        int r;
        Reset = 1'b1;
        if (!hold_req) ReqValid = 1'b0;
        r = cyc + 1;
        for (int c = r; c < N; c++) begin
            exp_rv[c] = 1'b0; exp_fl[c] = 1'b0; exp_mw[c] = 1'b0; exp_mr[c] = 1'b0;
            exp_busy[c] = 1'b0; exp_mdv[c] = 1'b0; rd_set[c] = 1'b0; rd_zero[c] = 1'b0;
        end
        if (r < N) rd_zero[r] = 1'b1;
        next_edge = r + 1;
        while (cyc < r) @(negedge CLK);
        #1;
        Reset = 1'b0;
        ReqValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        do_reset(1'b0);
        rd_m = 16'h0000;
        chk1("rst_ReqReady", ReqReady, 1'b1);
        chk1("rst_RespValid", RespValid, 1'b0);
        chk16("rst_RespData", RespData, 16'h0000);
        chk1("rst_Fault", Fault, 1'b0);
        chk1("rst_MemoryWrite", MemoryWrite, 1'b0);
        chk1("rst_MemoryRead", MemoryRead, 1'b0);
        chk16("rst_MemAddress", MemAddress, 16'h0000);
        chk16("rst_MemData", MemData, 16'h0000);
        chk_en = 1'b1;

        // Store then load
        req(1'b1, 16'h0010, 16'hBEEF);
        chk1("st_access_mw", MemoryWrite, 1'b1);
        chk1("st_access_ready", ReqReady, 1'b0);
        idle(1);
        chk1("st_resp_lat2", RespValid, 1'b1);
        idle(1);
        req(1'b0, 16'h0010, 16'h0000);
        idle(1);
        chk1("ld_not_yet", RespValid, 1'b0);
        idle(1);
        chk1("ld_resp_lat3", RespValid, 1'b1);
        chk16("ld_data", RespData, 16'hBEEF);
        chk1("ld_fault", Fault, 1'b0);
        idle(1);

        // Unaligned load
        req(1'b0, 16'h0011, 16'h0000);
`ifdef MEM_FAULT_CHECK_EN
        chk1("unal_rv", RespValid, 1'b1);
        chk1("unal_fault", Fault, 1'b1);
        chk1("unal_mr", MemoryRead, 1'b0);
        chk16("unal_data_kept", RespData, 16'hBEEF);
        idle(1);
`else
        idle(2);
        chk16("unal_alias", RespData, 16'hBEEF);
        idle(1);
`endif

        // Out-of-range load
        req(1'b1, 16'h0000, 16'h5A5A);
        idle(2);
        req(1'b0, 16'h0800, 16'h0000);
`ifdef MEM_FAULT_CHECK_EN
        chk1("oor_fault", Fault, 1'b1);
        chk1("oor_rv", RespValid, 1'b1);
        idle(1);
`else
        idle(2);
        chk16("oor_alias", RespData, 16'h5A5A);
        idle(1);
`endif

        // Back-to-back stores and loads with ReqValid held
        req(1'b1, 16'h0000, 16'h1111);
        req(1'b1, 16'h0002, 16'h2222);
        req(1'b1, 16'h0004, 16'h3333);
        req(1'b0, 16'h0000, 16'h0000);
        req(1'b0, 16'h0002, 16'h0000);
        req(1'b0, 16'h0004, 16'h0000);
        idle(2);
        chk16("b2b_last_load", RespData, 16'h3333);
        idle(1);

`ifdef MEM_FAULT_CHECK_EN
        // Fault followed immediately by a load accepted in RESP
        req(1'b0, 16'h0003, 16'h0000);
        req(1'b0, 16'h0002, 16'h0000);
        idle(2);
        chk16("fault_then_load", RespData, 16'h2222);
        idle(1);
`endif

        // Reset during the ACCESS cycle of a store
        req(1'b1, 16'h0020, 16'h1234);
        do_reset(1'b0);
        chk1("rstacc_rv", RespValid, 1'b0);
        chk16("rstacc_addr", MemAddress, 16'h0000);
        chk16("rstacc_data", MemData, 16'h0000);
        chk16("rstacc_rdata", RespData, 16'h0000);
        idle(1);
        req(1'b0, 16'h0020, 16'h0000);
        idle(2);
        chk16("rstacc_committed", RespData, 16'h1234);
        idle(1);

        // Reset during CAPTURE of a load
        req(1'b0, 16'h0010, 16'h0000);
        idle(1);
        do_reset(1'b0);
        chk16("rstcap_rdata", RespData, 16'h0000);
        chk1("rstcap_ready", ReqReady, 1'b1);
        idle(3);

        // Reset and ReqValid on the same edge: request must be dropped
        ReqWrite = 1'b1; ReqAddress = 16'h0030; ReqData = 16'h7777; ReqValid = 1'b1;
        do_reset(1'b1);
        idle(2);
        req(1'b0, 16'h0030, 16'h0000);
        idle(2);
        chk16("rst_wins", RespData, 16'h0000);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request/response front end placed directly upstream of the 16-bit data memory wrapper in the accumulator processor. It accepts load/store requests from the control unit over a valid/ready handshake, checks byte addresses for alignment and range, drives the memory's write/read strobes from registers, absorbs the memory's one-cycle synchronous read latency, and returns load data with a completion pulse. Faulting requests never reach memory.

## Interface
- ADDR_WIDTH, 16: byte address width.
- DATA_WIDTH, 16: data word width.
- WORD_ADDR_BITS, 10: memory word index width; the memory holds 1024 words, so byte addresses 0x0000–0x07FE are legal.

- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request this cycle.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddress  in  16  byte address.
- ReqData  in  16  store data.
- RespValid  out  1  one-cycle completion pulse.
- RespData  out  16  load result; valid while RespValid=1 after a load.
- Fault  out  1  request rejected; meaningful while RespValid=1.
- MemData  out  16  to memory Data.
- MemAddress  out  16  to memory Address; the memory uses bits [10:1].
- MemoryWrite  out  1  memory write enable.
- MemoryRead  out  1  read strobe; informational, the memory read is always active.
- MemOutput  in  16  from memory Output; registered read data.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- ReqReady = 1 in IDLE and in RESP, 0 otherwise. A request is accepted on an edge where ReqValid && ReqReady.
- At acceptance, latch ReqWrite, ReqAddress and ReqData into MemAddress/MemData and evaluate the fault check:
  - Faulting request: go to RESP with Fault=1. MemoryWrite and MemoryRead stay 0.
  - Store: go to ACCESS with MemoryWrite=1.
  - Load: go to ACCESS with MemoryRead=1.
- ACCESS lasts exactly one cycle; the memory samples the address and data at its closing edge. Next state is RESP for a store and CAPTURE for a load. MemoryWrite and MemoryRead return to 0 on leaving ACCESS.
- CAPTURE: MemOutput is valid. Register it into RespData at the closing edge and go to RESP.
- RESP: RespValid=1 for exactly one cycle. Then go to IDLE, or go straight into the next request if one is accepted in this cycle.
- After a store or a fault, RespData keeps its previous value.
- Fault is cleared when the next request is accepted.
- MemAddress and MemData hold their last values while idle.
- Requests that arrive while ReqReady=0 are ignored. The requester must hold ReqValid.

## Timing
- Reset values: state IDLE, ReqReady 1, RespValid 0, RespData 0x0000, Fault 0, MemoryWrite 0, MemoryRead 0, MemAddress 0x0000, MemData 0x0000.
- Latency from the accept edge to RespValid:
  - load: 3 cycles
  - store: 2 cycles
  - fault: 1 cycle
- Throughput with back-to-back requests (accepted in RESP):
  - one load per 3 cycles
  - one store per 2 cycles
- Reset while in ACCESS with MemoryWrite=1: the memory still commits that write at the same edge. No response is produced, and all outputs take their reset values.
- Reset during CAPTURE or RESP drops the pending response.
- If Reset and ReqValid are high on the same edge, Reset wins and the request is not accepted.

## Configuration
- MEM_FAULT_CHECK_EN defined:
  - A request faults when ReqAddress[0]=1 (unaligned) or ReqAddress[15:11]≠0 (out of range).
  - Faulting requests follow the 1-cycle fault path.
- MEM_FAULT_CHECK_EN undefined:
  - No checks are made. Fault is tied to 0.
  - Every request goes to memory, with ReqAddress[15:11] and [0] ignored (aliasing).

## Structure
- Shared package mem_access_pkg:
  - state enum (IDLE, ACCESS, CAPTURE, RESP)
  - MEM_WORDS = 1024
  - MEM_MAX_BYTE_ADDR = 16'h07FE
  - the width constants
- Sub-module mem_addr_check: combinational alignment/range check producing the fault bit. It is instantiated only under MEM_FAULT_CHECK_EN.

## Test plan
- Store 0xBEEF to 0x0010, then load 0x0010 → store RespValid 2 cycles after accept, load RespValid 3 cycles after accept, RespData=0xBEEF, Fault=0.
- Load 0x0011 with the check enabled → RespValid+Fault 1 cycle after accept, MemoryWrite/MemoryRead never asserted, RespData unchanged.
- Load 0x0800 with the check enabled → Fault=1. With the check disabled → returns the data stored at 0x0000.
- Hold ReqValid high for stores to 0x0000, 0x0002, 0x0004 → accepts every 2 cycles, ReqReady low during ACCESS, all three words readable afterwards.
- Assert Reset during the ACCESS cycle of a store of 0x1234 to 0x0020 → no RespValid, outputs at reset values, a later load of 0x0020 returns 0x1234.
- Assert Reset during the CAPTURE cycle of a load → RespValid never asserted, RespData=0x0000, ReqReady=1 on the next cycle.
